// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed 4-digit seven-segment scan controller with
// frame-synchronous double buffering, leading-zero suppression and digit blinking.
module display_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        src_clk,
    input  logic        src_rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        load,
    input  logic        lz_en,
    input  logic        blink_en,
    input  logic [3:0]  blink_mask,
    output logic [1:0]  select,
    output logic [3:0]  digit_val,
    output logic        dp,
    output logic        blank,
    output logic        frame_start,
    output logic        pending
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   act_val_q, act_val_d, sh_val_q, sh_val_d;
    logic [3:0]    act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic          pend_q, pend_d;
    logic [FW-1:0] fc_q, fc_d;
    logic          phase_q, phase_d;
    logic [3:0]    digit_val_q, digit_val_d;
    logic          dp_q, dp_d, blank_q, blank_d, fs_q, fs_d;
    logic          tick, wrap, fc_end;
    logic          z3, z2, z1;
    logic [3:0]    sup;

    always_comb begin
        tick        = cnt_q == CW'(REFRESH_DIV - 1);
        wrap        = tick && sel_q == 2'd3;
        fc_end      = fc_q == FW'(BLINK_FRAMES - 1);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        sel_d       = tick ? sel_q + 2'd1 : sel_q;
        sh_val_d    = load ? value : sh_val_q;
        sh_dp_d     = load ? dp_mask : sh_dp_q;
        // a load coinciding with the wrap bypasses the shadow entirely
        act_val_d   = (wrap && load) ? value : (wrap && pend_q) ? sh_val_q : act_val_q;
        act_dp_d    = (wrap && load) ? dp_mask : (wrap && pend_q) ? sh_dp_q : act_dp_q;
        pend_d      = wrap ? 1'b0 : load ? 1'b1 : pend_q;
        fc_d        = wrap ? (fc_end ? '0 : fc_q + 1'b1) : fc_q;
        phase_d     = (wrap && fc_end) ? ~phase_q : phase_q;
        z3          = act_val_d[15:12] == 4'h0;
        z2          = act_val_d[11:8] == 4'h0;
        z1          = act_val_d[7:4] == 4'h0;
        sup         = {lz_en & z3, lz_en & z3 & z2, lz_en & z3 & z2 & z1, 1'b0};
        blank_d     = tick ? (sup[sel_d] | (blink_en & blink_mask[sel_d] & phase_d)) : blank_q;
        digit_val_d = tick ? act_val_d[4*sel_d +: 4] : digit_val_q;
        dp_d        = tick ? (act_dp_d[sel_d] & ~blank_d) : dp_q;
        fs_d        = wrap;
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            cnt_q       <= '0;
            sel_q       <= '0;
            act_val_q   <= '0;
            act_dp_q    <= '0;
            sh_val_q    <= '0;
            sh_dp_q     <= '0;
            pend_q      <= 1'b0;
            fc_q        <= '0;
            phase_q     <= 1'b0;
            digit_val_q <= '0;
            dp_q        <= 1'b0;
            blank_q     <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            act_val_q   <= act_val_d;
            act_dp_q    <= act_dp_d;
            sh_val_q    <= sh_val_d;
            sh_dp_q     <= sh_dp_d;
            pend_q      <= pend_d;
            fc_q        <= fc_d;
            phase_q     <= phase_d;
            digit_val_q <= digit_val_d;
            dp_q        <= dp_d;
            blank_q     <= blank_d;
            fs_q        <= fs_d;
        end
    end

    assign select      = sel_q;
    assign digit_val   = digit_val_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;
    assign pending     = pend_q;
endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexed scan controller that produces the per-digit drive (select, digit_val, dp, blank) for the four-digit seven-segment display stage.
- Holds a double-buffered 4-digit BCD value plus a decimal-point mask, and rotates through the digits at a fixed refresh rate.
- New values are applied only at frame boundaries, so a frame never shows a mix of old and new digits.
- Adds leading-zero suppression and per-digit blinking for the stopwatch adjust mode.

Parameters:
- REFRESH_DIV, 100000: src_clk cycles per digit slot. Minimum 2. Counter width is clog2(REFRESH_DIV).
- BLINK_FRAMES, 125: complete frames per blink-phase toggle. Minimum 1.

Ports:
- src_clk  in  1  system clock
- src_rst  in  1  synchronous active-high reset
- value  in  16  four BCD digits; [3:0]=digit0 (rightmost), [15:12]=digit3
- dp_mask  in  4  decimal point enable per digit; bit n = digit n
- load  in  1  one-cycle strobe; captures value and dp_mask
- lz_en  in  1  leading-zero suppression enable
- blink_en  in  1  blink enable
- blink_mask  in  4  digits subject to blinking
- select  out  2  digit index currently driven
- digit_val  out  4  BCD value for the selected digit
- dp  out  1  decimal point for the selected digit, active-high
- blank  out  1  selected digit must be dark
- frame_start  out  1  one-cycle pulse in the first cycle of select==0
- pending  out  1  a loaded value is waiting for the next frame boundary

Behaviour:
- Reset (synchronous, takes priority over all other activity, including mid-frame):
  - Outputs select, digit_val, dp, blank, frame_start and pending all go to 0.
  - Prescaler, active regs, shadow regs, frame counter and blink_phase also go to 0.
  - No frame_start pulse is produced on reset exit.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1, then returns to 0.
  - tick = (cnt == REFRESH_DIV-1).
  - On the tick edge, select <= select+1 (mod 4), so each slot lasts exactly REFRESH_DIV cycles.
- Wrap: the tick with select==3.
  - If pending==1, active_value/active_dp <= shadow and pending <= 0.
  - frame_start <= 1 for exactly one cycle.
  - Frame counter increments; on reaching BLINK_FRAMES-1 it clears and blink_phase toggles.
- Load:
  - When load is high, shadow <= {value, dp_mask} and pending <= 1.
  - A second load before the wrap overwrites the shadow; the last load wins.
  - Load in the same cycle as a wrap: the incoming value goes directly to active at that edge, and pending stays 0.
- Outputs are registered and coherent: select, digit_val, dp and blank all update on the same edge. Each is computed from the next select and the post-wrap active data. There is zero skew between select and its data.
- digit_val = active_value[4*sel+3 : 4*sel].
- dp = active_dp[sel].
- Leading-zero suppression:
  - sup[n] = lz_en & (active digits n..3 all zero) for n = 3, 2, 1.
  - sup[0] = 0 always.
  - digit_val still carries the true value when suppressed.
- blank = sup[sel] | (blink_en & blink_mask[sel] & blink_phase).
- dp is forced to 0 whenever blank is 1.
- lz_en, blink_en and blink_mask are sampled live; a change takes effect at the next slot edge.
- Non-BCD nibbles (A–F) pass through unmodified. For lz purposes only 4'h0 counts as zero.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2 unless noted):
1. Scan timing: release reset, no load → select runs 0,1,2,3,0 with changes every 4 cycles; frame_start pulses once per 16 cycles; digit_val=0, dp=0, blank=0 throughout.
2. Load deferral: load 16'h1234 with dp_mask=4'b0100 while select=1 → pending=1 and old digits persist to the end of the frame. After the wrap, pending=0 and slots 0..3 show digit_val 4,3,2,1, with dp=1 only at select=2.
3. Load collisions:
   - Load 16'h1111 then 16'h2222 within the same frame → only 2222 is displayed.
   - Load 16'h5555 on the wrap cycle → select=0 shows 5 on the very next cycle and pending stays 0.
4. Leading zeros, lz_en=1:
   - value 16'h0050 → blank=1 at select 3 and 2; blank=0 at select 1 (5) and select 0 (0).
   - value 16'h0000 → only select 0 is unblanked.
   - value 16'h1000 → no blanking.
5. Blink: blink_en=1, blink_mask=4'b0001, value 16'h9999 with dp_mask=4'b0001 → at select 0, blank and dp alternate: frames 0–1 have blank=0, dp=1; frames 2–3 have blank=1, dp=0; and so on. Other digits never blank.
6. Reset mid-operation: assert src_rst at select=2 with pending=1 → on the next edge select=0, all outputs are 0 and pending=0. After release, the first tick occurs 4 cycles later.
